// File: rtl/risc16_fetch_unit.sv
// RiSC-16 instruction fetch front end: issues word fetches to a synchronous-read
// instruction memory, buffers responses in a prefetch queue, and hands them to decode.
module risc16_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [15:0]              imem_addr,
    input  logic [15:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [15:0]              redirect_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [15:0]              inst,
    output logic [15:0]              inst_pc,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_INC   = AW'(1);
    localparam logic [AW+1:0] CREDIT_MX = (AW+2)'(DEPTH);

    logic [15:0]   fetch_pc;
    logic [15:0]   inflight_pc;
    logic          inflight;
    logic [15:0]   q_inst [DEPTH];
    logic [15:0]   q_pc   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [15:0]   hold_inst;
    logic [15:0]   hold_pc;
    logic          pop;
    logic          push;
    logic [AW+1:0] credit;

    // The in-flight request is counted against queue space so a response always has a slot.
    always_comb begin
        pop      = inst_valid & inst_ready;
        push     = inflight & ~redirect;
        credit   = {1'b0, count} + {{(AW+1){1'b0}}, inflight} - {{(AW+1){1'b0}}, pop};
        imem_req = ~rst & ~redirect & (credit < CREDIT_MX);
    end

    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign level      = count;

    // When the queue is empty the outputs show the last presented instruction.
    assign inst    = inst_valid ? q_inst[rd_ptr] : hold_inst;
    assign inst_pc = inst_valid ? q_pc[rd_ptr]   : hold_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            hold_inst   <= '0;
            hold_pc     <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc;
                inflight <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (imem_req) begin
                    fetch_pc    <= fetch_pc + 16'd1;
                    inflight_pc <= fetch_pc;
                end
                inflight <= imem_req;
                if (push) wr_ptr <= wr_ptr + PTR_INC;
                if (pop)  rd_ptr <= rd_ptr + PTR_INC;
                count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
            if (inst_valid) begin
                hold_inst <= inst;
                hold_pc   <= inst_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= inflight_pc;
        end
    end

endmodule

// File: doc/risc16_fetch_unit.md
Name: risc16_fetch_unit

Overview:
- Instruction-fetch front end for the RiSC-16 core. Sits directly upstream of the decode/execute stage.
- Generates word addresses to a synchronous-read instruction memory and buffers returned instructions in a prefetch queue.
- Presents instructions with their PC to decode over a valid/ready handshake.
- Accepts a redirect (BEQ taken, JALR) from execute; a redirect flushes all buffered and in-flight fetches.

Parameters:
- DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 16'h0000: first fetch address after reset.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- imem_req, output, 1: fetch request this cycle.
- imem_addr, output, 16: word address of the request.
- imem_rdata, input, 16: instruction; valid exactly one cycle after imem_req.
- redirect, input, 1: flush and refetch from redirect_pc.
- redirect_pc, input, 16: new fetch address.
- inst_valid, output, 1: inst/inst_pc hold a valid instruction.
- inst_ready, input, 1: decode accepts the instruction.
- inst, output, 16: instruction word.
- inst_pc, output, 16: word address of inst.
- level, output, log2(DEPTH)+1: current queue occupancy.

Behaviour:
- State:
  - fetch_pc, 16 bits.
  - inflight flag plus inflight_pc.
  - DEPTH-entry circular queue of {inst, pc}, with read pointer, write pointer and count.
- Reset (rst high, asynchronous, no clock needed):
  - fetch_pc=RESET_PC; inflight=0; count=0; pointers=0.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0, level=0.
  - Any in-flight response is discarded.
- Request issue (combinational):
  - pop = inst_valid & inst_ready.
  - imem_req = !rst & !redirect & (count + inflight - pop < DEPTH).
  - imem_addr = fetch_pc.
- On an edge with imem_req=1:
  - fetch_pc <= fetch_pc+1. Wraps 16'hFFFF -> 16'h0000 with no flag.
  - inflight <= 1; inflight_pc <= fetch_pc.
- On an edge with imem_req=0 and no redirect: inflight <= 0.
- Response: in the cycle after a request, imem_rdata is written at the write pointer with inflight_pc, on the closing edge, unless redirect=1 in that cycle.
- Latency: request in cycle N, data on imem_rdata in N+1, inst_valid in N+2. There is no bypass from imem_rdata to inst.
- Throughput: with inst_ready held high, one instruction per cycle in steady state, for any DEPTH >= 2.
- Output:
  - inst_valid = (count != 0).
  - inst and inst_pc come from the queue head.
  - When inst_valid=0, inst and inst_pc hold their last values; they read 0 after reset.
  - While inst_valid=1 and inst_ready=0, inst and inst_pc are stable.
  - inst_ready is ignored when inst_valid=0.
- Ordering: strict program order; no drops or duplicates absent a redirect.
- Redirect (sampled on the edge):
  - Queue cleared: count=0, pointers=0. Any response arriving that cycle is discarded. inflight <= 0.
  - fetch_pc <= redirect_pc.
  - imem_req=0 during the redirect cycle; the first request to redirect_pc is issued the following cycle.
  - If a handshake completes in the redirect cycle, that instruction counts as consumed and is not re-presented.
  - Back-to-back redirects: the last one wins.
- Occupancy: level = count. Count never exceeds DEPTH, because the credit check counts the in-flight request.
- Simultaneous push and pop: count unchanged, both pointers advance, and each pointer wraps modulo DEPTH.

Test Plan:
1. Reset release with inst_ready=1 and imem[i]=16'h0100+i -> imem_req=1, imem_addr=0 in cycle 0. inst_valid rises in cycle 2 with inst=16'h0100, inst_pc=0. Thereafter one instruction per cycle: pc 1, 2, 3 with inst 0x0101, 0x0102, 0x0103.
2. inst_ready=0 from reset -> level climbs to 4 and imem_req drops to 0 with fetch_pc=4. inst stays 16'h0100 throughout. Releasing inst_ready delivers pcs 0..7 in order, with no gap once steady.
3. Redirect to 16'h0020 while level=3 and a response is in flight -> next cycle inst_valid=0, level=0 and imem_addr=16'h0020. The stale response is never delivered. The first delivered inst_pc is 16'h0020, two cycles after the request.
4. Redirect to 16'hFFFE with inst_ready=1 -> delivered inst_pc sequence 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001.
5. Assert rst mid-stream between clock edges while inst_valid=1 -> inst_valid, imem_req, level, inst and inst_pc go to 0 immediately. After release, fetching restarts at RESET_PC.
6. Redirect coincident with an accepted handshake (inst_pc=5) -> pc 5 is delivered exactly once. The next delivered instruction is from redirect_pc, and level is 0 on the following cycle.
